// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_WIDTH      = 16;
    localparam int DEF_TIMEOUT    = 64;

    // Next requester index after idx, wrapping with a compare so any count works.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    int               idx;
    logic [PTR_W-1:0] idx_w;

    // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and take the first active request.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = PTR_W'(idx);
            if (!any && req[idx_w]) begin
                any             = 1'b1;
                grant_oh[idx_w] = 1'b1;
                grant_idx       = idx_w;
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port among NUM_REQ
// requesters, one transaction at a time, with a mem_ready watchdog.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [WIDTH-1:0]              rsp_rdata,
    output logic                          mem_valid,
    output logic                          mem_wr_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]              mem_wdata,
    input  logic                          mem_ready,
    input  logic [WIDTH-1:0]              mem_rdata,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0]      grant_oh_q, grant_oh_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    mem_wr_rd_q, mem_wr_rd_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]        mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic [NUM_REQ-1:0]      req_done_q, req_done_d;
    logic [NUM_REQ-1:0]      req_err_q, req_err_d;
    logic                    busy_q, busy_d;

    logic [NUM_REQ-1:0]      pick_oh;
    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    handshake;
    logic                    timeout_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign handshake   = (state_q == ISSUE) && mem_valid_q && mem_ready;
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ISSUE) && !mem_ready &&
                         (timer_q == TMR_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant, wait for accept or watchdog, one response cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   if (handshake || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: command latch at grant, completion, pointer advance.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        timer_d     = timer_q;
        mem_valid_d = mem_valid_q;
        mem_wr_rd_d = mem_wr_rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;
        req_done_d  = '0;
        req_err_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_idx_d = pick_idx;
                    grant_oh_d  = pick_oh;
                    mem_valid_d = 1'b1;
                    mem_wr_rd_d = req_wr_rd[pick_idx];
                    mem_addr_d  = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d = req_wdata[int'(pick_idx)*WIDTH +: WIDTH];
                    busy_d      = 1'b1;
                    timer_d     = '0;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    mem_valid_d = 1'b0;
                    if (!mem_wr_rd_q) begin
                        rsp_rdata_d = mem_rdata;
                    end
                    req_done_d = grant_oh_q;
                    rr_ptr_d   = PTR_W'(wrap_inc(int'(grant_idx_q), NUM_REQ));
                end else if (timeout_hit) begin
                    mem_valid_d = 1'b0;
                    req_done_d  = grant_oh_q;
                    req_err_d   = grant_oh_q;
                    rr_ptr_d    = PTR_W'(wrap_inc(int'(grant_idx_q), NUM_REQ));
                end else if (TIMEOUT != 0) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops everything, losing any in-flight command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            timer_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            req_done_q  <= '0;
            req_err_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            timer_q     <= timer_d;
            mem_valid_q <= mem_valid_d;
            mem_wr_rd_q <= mem_wr_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_done  = req_done_q;
    assign req_err   = req_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_wr_rd = mem_wr_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios followed by a
// randomized phase checked against a transaction-level round-robin model.
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_wr_rd;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_done;
    logic [3:0]  req_err;
    logic [15:0] rsp_rdata;
    logic        mem_valid;
    logic        mem_wr_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        busy;

    int          compareCount = 0;
    int          failCount = 0;
    logic [15:0] memArr [256];
    logic [15:0] refMem [256];
    int          memWait = 0;
    bit          memHang = 1'b0;
    int          waitCnt = 0;

    bit          cmdWr [4];
    logic [7:0]  cmdAddr [4];
    logic [15:0] cmdWdata [4];

    mem_rr_arbiter #(
        .NUM_REQ    (4),
        .ADDR_WIDTH (8),
        .WIDTH      (16),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wr_rd (req_wr_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .rsp_rdata (rsp_rdata),
        .mem_valid (mem_valid),
        .mem_wr_rd (mem_wr_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory responder: accepts a command memWait cycles after mem_valid rises, or never when hung.
    always @(negedge clk) begin
        if (!rst) begin
            mem_ready = 1'b0;
            waitCnt   = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            waitCnt   = 0;
        end else if (mem_valid && !memHang) begin
            if (waitCnt >= memWait) begin
                mem_ready = 1'b1;
                if (mem_wr_rd) begin
                    mem_rdata        = 16'($urandom);
                    memArr[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = memArr[mem_addr];
                end
            end else begin
                waitCnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input bit valid, input bit wr,
                                 input logic [7:0] addr, input logic [15:0] wdata);
        req_valid[idx]          = valid;
        req_wr_rd[idx]          = wr;
        req_addr[idx*8 +: 8]    = addr;
        req_wdata[idx*16 +: 16] = wdata;
        cmdWr[idx]              = wr;
        cmdAddr[idx]            = addr;
        cmdWdata[idx]           = wdata;
    endtask

    task automatic waitForDone(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (req_done == 4'b0 && req_err == 4'b0 && cycles < 40);
        checkOutput("doneWithinBudget", 32'(req_done != 4'b0 || req_err != 4'b0), 32'd1);
    endtask

    function automatic int rrScan(input int ptr, input logic [3:0] pend);
        for (int k = 0; k < 4; k++) begin
            if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        int          cycles;
        int          validCycles;
        logic [15:0] expRsp;
        int          expPtr;
        int          expGrant;
        logic [3:0]  pending;
        int          doneCount;
        logic [3:0]  expOrder [5];

        rst       = 1'b0;
        req_valid = '0;
        req_wr_rd = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) memArr[i] = 16'h0;
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 1'b0, 8'h0, 16'h0);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstMemValid", 32'(mem_valid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(req_done), 32'd0);
        checkOutput("rstErr", 32'(req_err), 32'd0);
        checkOutput("rstRdata", 32'(rsp_rdata), 32'd0);
        checkOutput("rstAddr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single read from requester 1, memory answers after 2 wait cycles.
        $display("[TB] single read");
        @(negedge clk);
        memArr[8'h10] = 16'hBEEF;
        memWait = 2;
        applyStimulus(1, 1'b1, 1'b0, 8'h10, 16'h0);
        @(negedge clk);
        checkOutput("t1MemValidNext", 32'(mem_valid), 32'd1);
        checkOutput("t1Busy", 32'(busy), 32'd1);
        checkOutput("t1Addr", 32'(mem_addr), 32'h10);
        checkOutput("t1WrRd", 32'(mem_wr_rd), 32'd0);
        waitForDone(cycles);
        checkOutput("t1Latency", 32'(cycles), 32'd3);
        checkOutput("t1Done", 32'(req_done), 32'b0010);
        checkOutput("t1Err", 32'(req_err), 32'd0);
        checkOutput("t1Rdata", 32'(rsp_rdata), 32'hBEEF);
        applyStimulus(1, 1'b0, 1'b0, 8'h0, 16'h0);
        @(negedge clk);
        checkOutput("t1DonePulse", 32'(req_done), 32'd0);
        checkOutput("t1BusyDrop", 32'(busy), 32'd0);
        expRsp = 16'hBEEF;

        // All four requesters held from reset with zero-wait memory.
        $display("[TB] four-way round robin");
        rst = 1'b0;
        memWait = 0;
        for (int i = 0; i < 4; i++) begin
            memArr[8'(i * 4)] = 16'hA000 + 16'(i);
            applyStimulus(i, 1'b1, 1'b0, 8'(i * 4), 16'h0);
        end
        expOrder[0] = 4'b0001;
        expOrder[1] = 4'b0010;
        expOrder[2] = 4'b0100;
        expOrder[3] = 4'b1000;
        expOrder[4] = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            waitForDone(cycles);
            if (n > 0) checkOutput("t2Spacing", 32'(cycles), 32'd3);
            checkOutput("t2Order", 32'(req_done), 32'(expOrder[n]));
            checkOutput("t2Rdata", 32'(rsp_rdata), 32'(16'hA000 + 16'(n % 4)));
        end
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 1'b0, 8'h0, 16'h0);
        expRsp = 16'hA000;
        @(negedge clk);
        checkOutput("t2DonePulse", 32'(req_done), 32'd0);

        // Write from requester 2 with a slow memory.
        $display("[TB] write");
        memWait = 3;
        applyStimulus(2, 1'b1, 1'b1, 8'h7F, 16'h1234);
        cycles = 0;
        validCycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (mem_valid) begin
                validCycles++;
                checkOutput("t3WrRd", 32'(mem_wr_rd), 32'd1);
                checkOutput("t3Addr", 32'(mem_addr), 32'h7F);
                checkOutput("t3Wdata", 32'(mem_wdata), 32'h1234);
            end
        end while (req_done == 4'b0 && cycles < 40);
        checkOutput("t3ValidCycles", 32'(validCycles), 32'd4);
        checkOutput("t3Done", 32'(req_done), 32'b0100);
        checkOutput("t3Err", 32'(req_err), 32'd0);
        checkOutput("t3RdataKept", 32'(rsp_rdata), 32'(expRsp));
        checkOutput("t3MemWritten", 32'(memArr[8'h7F]), 32'h1234);
        applyStimulus(2, 1'b0, 1'b0, 8'h0, 16'h0);

        // Watchdog abort on a hung memory, then normal service resumes.
        $display("[TB] watchdog");
        @(negedge clk);
        memHang = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 8'h55, 16'h0);
        @(negedge clk);
        checkOutput("t4MemValid", 32'(mem_valid), 32'd1);
        waitForDone(cycles);
        checkOutput("t4TimeoutCycles", 32'(cycles), 32'd8);
        checkOutput("t4Done", 32'(req_done), 32'b0010);
        checkOutput("t4Err", 32'(req_err), 32'b0010);
        checkOutput("t4RdataKept", 32'(rsp_rdata), 32'(expRsp));
        checkOutput("t4MemValidDrop", 32'(mem_valid), 32'd0);
        memHang = 1'b0;
        memWait = 1;
        memArr[8'h60] = 16'h6060;
        memArr[8'h70] = 16'h7070;
        applyStimulus(1, 1'b0, 1'b0, 8'h0, 16'h0);
        applyStimulus(0, 1'b1, 1'b0, 8'h60, 16'h0);
        applyStimulus(3, 1'b1, 1'b0, 8'h70, 16'h0);
        waitForDone(cycles);
        checkOutput("t4NextGrant", 32'(req_done), 32'b1000);
        checkOutput("t4NextErr", 32'(req_err), 32'd0);
        checkOutput("t4NextRdata", 32'(rsp_rdata), 32'h7070);
        applyStimulus(3, 1'b0, 1'b0, 8'h0, 16'h0);
        waitForDone(cycles);
        checkOutput("t4ThenReq0", 32'(req_done), 32'b0001);
        checkOutput("t4ThenRdata", 32'(rsp_rdata), 32'h6060);
        applyStimulus(0, 1'b0, 1'b0, 8'h0, 16'h0);

        // Reset while a command is outstanding.
        $display("[TB] reset mid-issue");
        @(negedge clk);
        memHang = 1'b1;
        applyStimulus(2, 1'b1, 1'b0, 8'h22, 16'h0);
        @(negedge clk);
        checkOutput("t5MemValid", 32'(mem_valid), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t5RstMemValid", 32'(mem_valid), 32'd0);
        checkOutput("t5RstBusy", 32'(busy), 32'd0);
        checkOutput("t5RstDone", 32'(req_done), 32'd0);
        checkOutput("t5RstRdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        memHang = 1'b0;
        memWait = 1;
        memArr[8'h20] = 16'h5A5A;
        memArr[8'h30] = 16'h3030;
        applyStimulus(2, 1'b0, 1'b0, 8'h0, 16'h0);
        applyStimulus(0, 1'b1, 1'b0, 8'h20, 16'h0);
        applyStimulus(3, 1'b1, 1'b0, 8'h30, 16'h0);
        rst = 1'b1;
        waitForDone(cycles);
        checkOutput("t5TieReq0", 32'(req_done), 32'b0001);
        checkOutput("t5Rdata", 32'(rsp_rdata), 32'h5A5A);
        applyStimulus(0, 1'b0, 1'b0, 8'h0, 16'h0);
        applyStimulus(3, 1'b0, 1'b0, 8'h0, 16'h0);

        // Requester 3 withdraws its request right after grant.
        $display("[TB] drop after grant");
        @(negedge clk);
        memWait = 2;
        memArr[8'h44] = 16'h0C0C;
        applyStimulus(3, 1'b1, 1'b0, 8'h44, 16'h0);
        @(negedge clk);
        checkOutput("t6Granted", 32'(mem_addr), 32'h44);
        applyStimulus(3, 1'b0, 1'b0, 8'h0, 16'h0);
        waitForDone(cycles);
        checkOutput("t6Done", 32'(req_done), 32'b1000);
        checkOutput("t6Rdata", 32'(rsp_rdata), 32'h0C0C);
        expRsp = 16'h0C0C;
        expPtr = 0;

        // Randomized traffic against a transaction-level model.
        $display("[TB] random traffic");
        for (int i = 0; i < 256; i++) begin
            refMem[i] = 16'($urandom);
            memArr[i] = refMem[i];
        end
        pending   = '0;
        expGrant  = -1;
        doneCount = 0;
        for (int cyc = 0; cyc < 3000 && doneCount < 150; cyc++) begin
            @(negedge clk);
            if (expGrant >= 0 && mem_valid) begin
                checkOutput("rndAddr", 32'(mem_addr), 32'(cmdAddr[expGrant]));
                checkOutput("rndWrRd", 32'(mem_wr_rd), 32'(cmdWr[expGrant]));
                if (cmdWr[expGrant]) checkOutput("rndWdata", 32'(mem_wdata), 32'(cmdWdata[expGrant]));
            end
            if (req_done != 4'b0 || req_err != 4'b0) begin
                if (expGrant < 0) begin
                    checkOutput("rndUnexpectedDone", 32'(req_done), 32'd0);
                end else begin
                    checkOutput("rndDone", 32'(req_done), 32'(4'b1 << expGrant));
                    checkOutput("rndErr", 32'(req_err), 32'd0);
                    if (cmdWr[expGrant]) refMem[cmdAddr[expGrant]] = cmdWdata[expGrant];
                    else expRsp = refMem[cmdAddr[expGrant]];
                    checkOutput("rndRdata", 32'(rsp_rdata), 32'(expRsp));
                    expPtr = (expGrant + 1) % 4;
                    pending[expGrant] = 1'b0;
                    applyStimulus(expGrant, 1'b0, 1'b0, 8'h0, 16'h0);
                    doneCount++;
                end
                for (int i = 0; i < 4; i++) begin
                    if (!pending[i] && $urandom_range(0, 1) == 1) begin
                        pending[i] = 1'b1;
                        applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
                    end
                end
                memWait  = $urandom_range(0, 3);
                expGrant = rrScan(expPtr, pending);
            end else if (pending == 4'b0) begin
                pending = 4'($urandom_range(1, 15));
                for (int i = 0; i < 4; i++) begin
                    if (pending[i]) applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
                end
                memWait  = $urandom_range(0, 3);
                expGrant = rrScan(expPtr, pending);
            end
        end
        checkOutput("rndDoneCount", 32'(doneCount), 32'd150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
